// File: rtl/gram_pkg.sv
// rtl/gram_pkg.sv - shared state type and result-width helper for the Gram-matrix engine
package gram_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // Wide enough for N products of full-scale operands.
    function automatic int gram_ow(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/dot_mac.sv
// rtl/dot_mac.sv - single unsigned multiply-accumulate, clear has priority over enable
module dot_mac #(
    parameter int DW = 8,
    parameter int OW = 18
) (
    input  logic          Clock,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [OW-1:0] acc
);

    logic [2*DW-1:0] prod;

    assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

    always_ff @(posedge Clock) begin
        if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + OW'(prod);
    end

endmodule

// File: rtl/gram_matrix_engine.sv
// rtl/gram_matrix_engine.sv - streaming G = A*A^T engine: row beats in, one G entry per beat out
module gram_matrix_engine
    import gram_pkg::*;
#(
    parameter int  N          = 4,
    parameter int  DW         = 8,
    parameter int  UPPER_ONLY = 0,
    localparam int OW         = gram_ow(N, DW),
    localparam int IW         = $clog2(N)
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_row,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   out_data,
    output logic [IW-1:0]   out_row,
    output logic [IW-1:0]   out_col,
    output logic            out_last,
    output logic            busy
);

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t        state;
    logic [IW-1:0] rcnt;
    logic [IW-1:0] i;
    logic [IW-1:0] j;
    logic [IW-1:0] k;
    logic [DW-1:0] store [N][N];
    logic          mac_clr;
    logic          mac_en;
    logic [OW-1:0] acc;

    // Accumulator is cleared on every transition into COMPUTE; it then holds the
    // finished sum untouched through EMIT, so it doubles as the output data register.
    assign mac_clr = Reset
                   || (state == LOAD && in_valid && rcnt == LAST)
                   || (state == EMIT && out_ready && !out_last);
    assign mac_en  = (state == COMPUTE);
    assign out_data = acc;

    dot_mac #(
        .DW (DW),
        .OW (OW)
    ) u_mac (
        .Clock (Clock),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (store[i][k]),
        .b     (store[j][k]),
        .acc   (acc)
    );

    always_ff @(posedge Clock) begin
        if (!Reset && in_valid && in_ready) begin
            for (int c = 0; c < N; c++)
                store[rcnt][c] <= in_row[c*DW +: DW];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= LOAD;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            rcnt      <= '0;
            i         <= '0;
            j         <= '0;
            k         <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (rcnt == LAST) begin
                            rcnt     <= '0;
                            i        <= '0;
                            j        <= '0;
                            k        <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            state    <= COMPUTE;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (k == LAST) begin
                        k         <= '0;
                        out_row   <= i;
                        out_col   <= j;
                        out_last  <= (i == LAST) && (j == LAST);
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            i        <= '0;
                            j        <= '0;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= LOAD;
                        end else begin
                            state <= COMPUTE;
                            if (j == LAST) begin
                                j <= (UPPER_ONLY != 0) ? i + 1'b1 : '0;
                                i <= i + 1'b1;
                            end else begin
                                j <= j + 1'b1;
                            end
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_gram_matrix_engine.sv
// tb/tb_gram_matrix_engine.sv - randomized self-checking bench for gram_matrix_engine
module tb_gram_matrix_engine;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int OW = 2 * DW + 2;

    typedef struct {
        int r;
        int c;
        int v;
        bit last;
    } entry_t;

    logic            Clock;
    logic            Reset;
    logic            in_valid, in_valid_u;
    logic            in_ready, in_ready_u;
    logic [N*DW-1:0] in_row;
    logic            out_valid, out_valid_u;
    logic            out_ready;
    logic [OW-1:0]   out_data, out_data_u;
    logic [1:0]      out_row, out_row_u, out_col, out_col_u;
    logic            out_last, out_last_u;
    logic            busy, busy_u;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int p_last = 0;
    int mat [N][N];

    gram_matrix_engine #(.N(N), .DW(DW), .UPPER_ONLY(0)) dut (
        .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
        .out_col(out_col), .out_last(out_last), .busy(busy)
    );

    gram_matrix_engine #(.N(N), .DW(DW), .UPPER_ONLY(1)) dut_u (
        .Clock(Clock), .Reset(Reset), .in_valid(in_valid_u), .in_ready(in_ready_u), .in_row(in_row),
        .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u), .out_row(out_row_u),
        .out_col(out_col_u), .out_last(out_last_u), .busy(busy_u)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic int gval(input int a, input int b);
        int s = 0;
        for (int x = 0; x < N; x++) s += mat[a][x] * mat[b][x];
        return s;
    endfunction

    function automatic logic [N*DW-1:0] pack(input int r);
        logic [N*DW-1:0] v;
        for (int c = 0; c < N; c++) v[c*DW +: DW] = 8'(mat[r][c]);
        return v;
    endfunction

    task automatic set_identity();
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mat[r][c] = (r == c) ? 1 : 0;
    endtask

    task automatic set_const(input int v);
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mat[r][c] = v;
    endtask

    task automatic set_seq();
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mat[r][c] = r * N + c + 1;
    endtask

    task automatic set_rand();
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mat[r][c] = int'($urandom_range(0, 255));
    endtask

    task automatic load(input bit upper);
        int r = 0;
        int guard = 0;
        while (r < N && guard < 200) begin
            @(negedge Clock);
            guard++;
            in_row = pack(r);
            if (upper) in_valid_u = 1'b1; else in_valid = 1'b1;
            if ((upper ? in_ready_u : in_ready) === 1'b1) begin
                if (r == N - 1) p_last = cyc + 1;
                r++;
            end
        end
        @(negedge Clock);
        in_valid = 1'b0;
        in_valid_u = 1'b0;
        if (r < N) begin
            total++;
            $display("FAIL load_timeout: accepted %0d rows, want %0d", r, N);
        end
    endtask

    task automatic collect(input bit upper, input bit rnd, input bit hold_in);
        entry_t exp_q[$];
        int idx = 0;
        int guard = 0;
        int last_acc = -1;
        bit first = 1'b1;
        bit stalled = 1'b0;
        logic v, l, ir, rdy, bz, hl;
        logic [OW-1:0] d, hd;
        logic [1:0] r, c, hr, hc;
        for (int a = 0; a < N; a++)
            for (int b = (upper ? a : 0); b < N; b++)
                exp_q.push_back('{a, b, gval(a, b), (a == N - 1) && (b == N - 1)});
        while (idx < exp_q.size() && guard < 4000) begin
            @(negedge Clock);
            guard++;
            v  = upper ? out_valid_u : out_valid;
            l  = upper ? out_last_u  : out_last;
            ir = upper ? in_ready_u  : in_ready;
            d  = upper ? out_data_u  : out_data;
            r  = upper ? out_row_u   : out_row;
            c  = upper ? out_col_u   : out_col;
            if (stalled) begin
                total++;
                if (v !== 1'b1 || d !== hd || r !== hr || c !== hc || l !== hl)
                    $display("FAIL stall_hold: got v=%0b d=%0d (%0d,%0d) last=%0b, want v=1 d=%0d (%0d,%0d) last=%0b",
                             v, d, r, c, l, hd, hr, hc, hl);
                else passed++;
                stalled = 1'b0;
            end
            if (hold_in) begin
                in_valid = 1'b1;
                in_row = $urandom;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            if (v === 1'b1) begin
                total++;
                if (ir !== 1'b0) $display("FAIL in_ready_low: got %0b, want 0", ir);
                else passed++;
                if (first) begin
                    first = 1'b0;
                    total++;
                    if (cyc - p_last != N) $display("FAIL latency: got %0d cycles, want %0d", cyc - p_last, N);
                    else passed++;
                end
                if (rdy) begin
                    total++;
                    if (d !== OW'(exp_q[idx].v) || r !== 2'(exp_q[idx].r) || c !== 2'(exp_q[idx].c) ||
                        l !== exp_q[idx].last)
                        $display("FAIL entry%0d: got d=%0d (%0d,%0d) last=%0b, want d=%0d (%0d,%0d) last=%0b",
                                 idx, d, r, c, l, exp_q[idx].v, exp_q[idx].r, exp_q[idx].c, exp_q[idx].last);
                    else passed++;
                    if (!rnd && last_acc >= 0) begin
                        total++;
                        if (cyc - last_acc != N + 1)
                            $display("FAIL spacing: got %0d cycles, want %0d", cyc - last_acc, N + 1);
                        else passed++;
                    end
                    last_acc = cyc;
                    idx++;
                    if (hold_in && idx == exp_q.size()) in_valid = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hd = d; hr = r; hc = c; hl = l;
                end
            end
        end
        if (idx < exp_q.size()) begin
            total++;
            $display("FAIL collect_timeout: got %0d entries, want %0d", idx, exp_q.size());
        end
        @(negedge Clock);
        out_ready = 1'b0;
        v  = upper ? out_valid_u : out_valid;
        ir = upper ? in_ready_u  : in_ready;
        bz = upper ? busy_u      : busy;
        total++;
        if (v !== 1'b0 || ir !== 1'b1 || bz !== 1'b0)
            $display("FAIL return_load: got valid=%0b in_ready=%0b busy=%0b, want 0 1 0", v, ir, bz);
        else passed++;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
            out_data !== '0 || out_row !== 2'd0 || out_col !== 2'd0)
            $display("FAIL reset_state: got rdy=%0b v=%0b last=%0b busy=%0b d=%0d (%0d,%0d), want 1 0 0 0 0 (0,0)",
                     in_ready, out_valid, out_last, busy, out_data, out_row, out_col);
        else passed++;
        Reset = 1'b0;
    endtask

    task automatic test_identity();
        set_identity();
        load(1'b0);
        collect(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_full_scale();
        set_const(255);
        load(1'b0);
        collect(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_sequence();
        set_seq();
        load(1'b0);
        collect(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        set_seq();
        load(1'b0);
        collect(1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_upper();
        set_seq();
        load(1'b1);
        collect(1'b1, 1'b0, 1'b0);
        set_rand();
        load(1'b1);
        collect(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        set_identity();
        load(1'b0);
        while (out_valid !== 1'b1 && guard < 50) begin
            @(negedge Clock);
            guard++;
        end
        out_ready = 1'b1;
        @(negedge Clock);
        out_ready = 1'b0;
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL second_compute: got busy=%0b valid=%0b, want 1 0", busy, out_valid);
        else passed++;
        Reset = 1'b1;
        @(negedge Clock);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_abort: got valid=%0b in_ready=%0b busy=%0b, want 0 1 0", out_valid, in_ready, busy);
        else passed++;
        Reset = 1'b0;
        load(1'b0);
        collect(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int m = 0; m < 2; m++) begin
            set_rand();
            load(1'b0);
            collect(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        Reset = 1'b1;
        in_valid = 1'b0;
        in_valid_u = 1'b0;
        out_ready = 1'b0;
        in_row = '0;
        test_reset();
        test_identity();
        test_full_scale();
        test_sequence();
        test_backpressure();
        test_upper();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
